sprite_compositor: RTL and testbench

Parametrised per-pixel compositor for the VGA path. It layers NUM_SPRITES rectangular indexed-colour sprites over a programmable background colour. Each layer is hit-tested against DrawX/DrawY, and the block fetches sprite texels from external ROMs. Transparent texels fall through to lower layers, and the winning palette index resolves to 24-bit RGB through a writable palette. It replaces the fixed-position, single-scene colour mapper with a runtime-programmable sprite table and a fixed-latency pipeline.

---
 rtl/sprite_compositor.sv | 196 +++++++++++++++++++
 tb/tb_sprite_compositor.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// sprite_compositor: layers NUM_SPRITES indexed-colour sprites over a background
// colour through a fixed 3-cycle pipeline (S1 hit/address, S2 winner, S3 palette).
// Layer 0 has highest priority. Texel ROMs are external with one cycle of read latency.
// Build option: define COLLISION_EN for sticky per-layer collision flags.
module sprite_compositor #(
  parameter int unsigned NUM_SPRITES = 8,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned IDX_W       = 6,
  parameter int unsigned TRANS_IDX   = 0,
  localparam int unsigned SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          pix_valid,
  input  logic [COORD_W-1:0]            DrawX,
  input  logic [COORD_W-1:0]            DrawY,
  input  logic                          frame_start,
  input  logic                          spr_we,
  input  logic [SEL_W-1:0]              spr_sel,
  input  logic                          spr_en,
  input  logic [COORD_W-1:0]            spr_x,
  input  logic [COORD_W-1:0]            spr_y,
  input  logic [COORD_W-1:0]            spr_w,
  input  logic [COORD_W-1:0]            spr_h,
  input  logic [ADDR_W-1:0]             spr_base,
  input  logic                          pal_we,
  input  logic [IDX_W-1:0]              pal_addr,
  input  logic [23:0]                   pal_data,
  input  logic [23:0]                   bg_rgb,
  output logic [NUM_SPRITES*ADDR_W-1:0] rom_addr,
  input  logic [NUM_SPRITES*IDX_W-1:0]  rom_data,
  output logic                          rgb_valid,
  output logic [7:0]                    Red,
  output logic [7:0]                    Green,
  output logic [7:0]                    Blue,
  output logic [NUM_SPRITES-1:0]        collision
);

  localparam int unsigned PAL_N  = 2 ** IDX_W;
  localparam int unsigned PROD_W = 2 * COORD_W + 1;

  logic               en_q   [NUM_SPRITES];
  logic [COORD_W-1:0] x_q    [NUM_SPRITES];
  logic [COORD_W-1:0] y_q    [NUM_SPRITES];
  logic [COORD_W-1:0] w_q    [NUM_SPRITES];
  logic [COORD_W-1:0] h_q    [NUM_SPRITES];
  logic [ADDR_W-1:0]  base_q [NUM_SPRITES];
  logic [23:0]        pal_q  [PAL_N];

  logic [NUM_SPRITES-1:0]        hit_d, hit1_q, hit2_q;
  logic [NUM_SPRITES*ADDR_W-1:0] rom_addr_d, rom_addr_q;
  logic                          vld1_q, vld2_q, vld3_q, rgb_valid_q;
  logic [NUM_SPRITES-1:0]        opaque;
  logic                          win_d, win_q;
  logic [IDX_W-1:0]              idx_d, idx_q;
  logic [23:0]                   bg_q, rgb_d, rgb_q;

  // Extents are widened by one bit so x+w cannot wrap; a zero size fails the upper bound.
  function automatic logic layer_hit(input logic [COORD_W-1:0] px, py, sx, sy, sw, sh);
    logic [COORD_W:0] ex, ey;
    ex = {1'b0, sx} + {1'b0, sw};
    ey = {1'b0, sy} + {1'b0, sh};
    return ({1'b0, px} >= {1'b0, sx}) && ({1'b0, px} < ex) &&
           ({1'b0, py} >= {1'b0, sy}) && ({1'b0, py} < ey);
  endfunction

  function automatic logic [ADDR_W-1:0] layer_addr(input logic [COORD_W-1:0] px, py, sx, sy, sw,
                                                    input logic [ADDR_W-1:0] base);
    logic [COORD_W-1:0] dx, dy;
    logic [PROD_W-1:0]  off;
    dx  = px - sx;
    dy  = py - sy;
    off = PROD_W'(dy) * PROD_W'(sw) + PROD_W'(dx);
    return base + ADDR_W'(off);
  endfunction

  // Sprite table write port; a hit test on the same edge still sees the old entry.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        en_q[i]   <= 1'b0;
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        w_q[i]    <= '0;
        h_q[i]    <= '0;
        base_q[i] <= '0;
      end
    end else if (spr_we) begin
      en_q[spr_sel]   <= spr_en;
      x_q[spr_sel]    <= spr_x;
      y_q[spr_sel]    <= spr_y;
      w_q[spr_sel]    <= spr_w;
      h_q[spr_sel]    <= spr_h;
      base_q[spr_sel] <= spr_base;
    end
  end

  // Palette write port; an S3 read of the same entry on this edge returns the old colour.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < PAL_N; i++) pal_q[i] <= '0;
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  // S1: per-layer hit test and texel address; a missing layer presents address 0.
  always_comb begin
    hit_d      = '0;
    rom_addr_d = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      hit_d[i] = pix_valid && en_q[i] &&
                 layer_hit(DrawX, DrawY, x_q[i], y_q[i], w_q[i], h_q[i]);
      if (hit_d[i])
        rom_addr_d[i*ADDR_W +: ADDR_W] = layer_addr(DrawX, DrawY, x_q[i], y_q[i], w_q[i], base_q[i]);
    end
  end

  // S2: opaque layers from returned texels; the lowest-numbered opaque layer wins.
  always_comb begin
    opaque = '0;
    win_d  = 1'b0;
    idx_d  = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++)
      opaque[i] = hit2_q[i] && (rom_data[i*IDX_W +: IDX_W] != IDX_W'(TRANS_IDX));
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (opaque[i] && !win_d) begin
        win_d = 1'b1;
        idx_d = rom_data[i*IDX_W +: IDX_W];
      end
    end
  end

  // S3: palette lookup of the winner, background otherwise, black for invalid pixels.
  always_comb begin
    rgb_d = '0;
    if (vld3_q) rgb_d = win_q ? pal_q[idx_q] : bg_q;
  end

  // Pipeline registers; the hit vector is carried one extra stage to meet the ROM data.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      vld1_q      <= 1'b0;
      vld2_q      <= 1'b0;
      vld3_q      <= 1'b0;
      rgb_valid_q <= 1'b0;
      hit1_q      <= '0;
      hit2_q      <= '0;
      rom_addr_q  <= '0;
      win_q       <= 1'b0;
      idx_q       <= '0;
      bg_q        <= '0;
      rgb_q       <= '0;
    end else begin
      vld1_q      <= pix_valid;
      hit1_q      <= hit_d;
      rom_addr_q  <= rom_addr_d;
      vld2_q      <= vld1_q;
      hit2_q      <= hit1_q;
      vld3_q      <= vld2_q;
      win_q       <= win_d;
      idx_q       <= idx_d;
      bg_q        <= bg_rgb;
      rgb_valid_q <= vld3_q;
      rgb_q       <= rgb_d;
    end
  end

  assign rom_addr           = rom_addr_q;
  assign rgb_valid          = rgb_valid_q;
  assign {Red, Green, Blue} = rgb_q;

`ifdef COLLISION_EN
  logic [NUM_SPRITES-1:0] coll_d, coll_q;

  // Collision flags: frame_start clears first so a same-cycle collision still sets.
  always_comb begin
    coll_d = frame_start ? '0 : coll_q;
    if ($countones(opaque) >= 2) coll_d = coll_d | opaque;
  end

  // Sticky collision flag register.
  always_ff @(posedge Clk) begin
    if (!Reset) coll_q <= '0;
    else        coll_q <= coll_d;
  end

  assign collision = coll_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign collision          = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: the driver pushes expected colours computed
// by a coordinate-level reference model; a negedge monitor pops and compares outputs.
module tb_sprite_compositor;

  localparam int N  = 8;
  localparam int CW = 10;
  localparam int AW = 12;
  localparam int IW = 6;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              pix_valid = 1'b0;
  logic [CW-1:0]     DrawX = '0, DrawY = '0;
  logic              frame_start = 1'b0;
  logic              spr_we = 1'b0;
  logic [2:0]        spr_sel = '0;
  logic              spr_en = 1'b0;
  logic [CW-1:0]     spr_x = '0, spr_y = '0, spr_w = '0, spr_h = '0;
  logic [AW-1:0]     spr_base = '0;
  logic              pal_we = 1'b0;
  logic [IW-1:0]     pal_addr = '0;
  logic [23:0]       pal_data = '0;
  logic [23:0]       bg_rgb = '0;
  logic [N*AW-1:0]   rom_addr;
  logic [N*IW-1:0]   rom_data = '0;
  logic              rgb_valid;
  logic [7:0]        Red, Green, Blue;
  logic [N-1:0]      collision;

  sprite_compositor #(
    .NUM_SPRITES(N), .COORD_W(CW), .ADDR_W(AW), .IDX_W(IW), .TRANS_IDX(0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .spr_we(spr_we), .spr_sel(spr_sel), .spr_en(spr_en),
    .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h), .spr_base(spr_base),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data), .bg_rgb(bg_rgb),
    .rom_addr(rom_addr), .rom_data(rom_data), .rgb_valid(rgb_valid),
    .Red(Red), .Green(Green), .Blue(Blue), .collision(collision)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  typedef struct { bit en; int x; int y; int w; int h; int base; } spr_t;
  typedef struct { int unsigned rgb; int unsigned issue; } exp_t;
  spr_t         mspr [N];
  int unsigned  mpal [64];
  logic [IW-1:0] rom_mem [N][4096];
  int unsigned  mbg;
  logic [N-1:0] mcoll;
  exp_t         exp_q [$];
  exp_t         mon_e;
  int unsigned  cyc = 0;
  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Texel ROMs: one cycle of read latency
  always @(posedge Clk)
    for (int i = 0; i < N; i++) rom_data[i*IW +: IW] <= rom_mem[i][rom_addr[i*AW +: AW]];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) mspr[i] = '{0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 64; i++) mpal[i] = 0;
    mcoll = '0;
  endfunction

  // Topmost opaque sprite under (px,py) gives the colour; mask lists every opaque layer.
  function automatic void model_pixel(input int px, input int py,
                                      output int unsigned rgb, output logic [N-1:0] mask);
    bit found = 0;
    mask = '0;
    rgb  = mbg;
    for (int i = 0; i < N; i++) begin
      if (mspr[i].en && px >= mspr[i].x && px < mspr[i].x + mspr[i].w &&
          py >= mspr[i].y && py < mspr[i].y + mspr[i].h) begin
        int a;
        int t;
        a = (mspr[i].base + (py - mspr[i].y) * mspr[i].w + (px - mspr[i].x)) % 4096;
        t = rom_mem[i][a];
        if (t != 0) begin
          mask[i] = 1'b1;
          if (!found) begin
            found = 1;
            rgb   = mpal[t];
          end
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
    pix_valid   = 1'b0;
    spr_we      = 1'b0;
    pal_we      = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic drain();
    repeat (6) tick();
  endtask

  task automatic pixel(input int px, input int py, input bit v = 1'b1);
    int unsigned  rgb;
    logic [N-1:0] m;
    pix_valid = v;
    DrawX     = CW'(px);
    DrawY     = CW'(py);
    if (v && Reset) begin
      model_pixel(px, py, rgb, m);
      exp_q.push_back('{rgb, cyc + 1});
`ifdef COLLISION_EN
      if ($countones(m) >= 2) mcoll |= m;
`endif
    end
    tick();
  endtask

  task automatic spr_write(input int sel, input bit en, input int x, input int y,
                           input int w, input int h, input int base);
    spr_we = 1'b1; spr_sel = 3'(sel); spr_en = en;
    spr_x = CW'(x); spr_y = CW'(y); spr_w = CW'(w); spr_h = CW'(h); spr_base = AW'(base);
    mspr[sel] = '{en, x, y, w, h, base};
    tick();
  endtask

  task automatic pal_write(input int idx, input int unsigned val, input bit upd = 1'b1);
    pal_we = 1'b1; pal_addr = IW'(idx); pal_data = 24'(val);
    if (upd) mpal[idx] = val & 24'hFFFFFF;
    tick();
  endtask

  // Monitor: pop one expectation per valid output, check colour and latency
  always @(negedge Clk) begin
    if (mon_en) begin
      if (rgb_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: rgb_valid=1 rgb=%06h with no pixel outstanding",
                   {Red, Green, Blue});
        end else begin
          mon_e = exp_q.pop_front();
          check("rgb", {Red, Green, Blue}, mon_e.rgb);
          check("latency", cyc - mon_e.issue, 3);
        end
      end else begin
        check("idle_rgb", {Red, Green, Blue}, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 4096; j++)
        rom_mem[i][j] = ($urandom_range(0, 3) == 0) ? IW'(0) : IW'($urandom_range(1, 63));
    mbg    = 24'h24188A;
    bg_rgb = 24'h24188A;
    model_reset();

    // Reset with garbage on every input
    Reset = 1'b0;
    repeat (2) begin
      pix_valid = 1'b1; DrawX = CW'($urandom); DrawY = CW'($urandom);
      spr_we = 1'b1; spr_sel = 3'($urandom); spr_en = 1'b1;
      spr_x = CW'($urandom); spr_y = CW'($urandom); spr_w = CW'($urandom); spr_h = CW'($urandom);
      spr_base = AW'($urandom); pal_we = 1'b1; pal_addr = IW'($urandom);
      pal_data = 24'($urandom); frame_start = 1'b1;
      @(posedge Clk);
      #1;
    end
    check("rst_rgb_valid", rgb_valid, 0);
    check("rst_rgb", {Red, Green, Blue}, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_collision", collision, 0);
    pix_valid = 0; spr_we = 0; pal_we = 0; frame_start = 0;
    Reset  = 1'b1;
    mon_en = 1'b1;

    // No sprites: background
    pixel(10, 10);
    pixel(600, 400);
    drain();

    // Single sprite on layer 2
    pal_write(5, 24'hFF0000);
    for (int k = 0; k < 400; k++) rom_mem[2][12'h100 + k] = 6'd5;
    spr_write(2, 1, 200, 100, 20, 20, 12'h100);
    pixel(205, 103);
    check("rom_addr_l2", rom_addr[2*AW +: AW], 12'h141);
    check("rom_addr_l0_miss", rom_addr[0 +: AW], 0);
    pixel(220, 100);
    pixel(219, 119);
    pixel(199, 105);
    drain();

    // Overlap: transparent layer 0 reveals layer 3, then opaque layer 0 wins
    for (int k = 0; k < 256; k++) begin
      rom_mem[0][k]          = 6'd0;
      rom_mem[3][12'h800 + k] = 6'd7;
    end
    pal_write(7, 24'h0058F8);
    pal_write(9, 24'h123456);
    spr_write(0, 1, 50, 50, 16, 16, 0);
    spr_write(3, 1, 50, 50, 16, 16, 12'h800);
    pixel(55, 57);
    pixel(49, 50);
    drain();
    for (int k = 0; k < 256; k++) rom_mem[0][k] = 6'd9;
    pixel(55, 57);
    pixel(65, 65);
    drain();

    // Right-edge clipping and zero sizes
    for (int k = 0; k < 100; k++) rom_mem[6][12'h200 + k] = 6'd11;
    pal_write(11, 24'hA5A5A5);
    spr_write(6, 1, 630, 10, 20, 5, 12'h200);
    for (int x = 625; x < 640; x++) pixel(x, 12);
    for (int x = 0; x < 13; x++) pixel(x, 12);
    pixel(635, 15);
    spr_write(6, 1, 630, 10, 0, 5, 12'h200);
    pixel(630, 12);
    pixel(635, 12);
    spr_write(6, 1, 630, 10, 20, 0, 12'h200);
    pixel(630, 10);
    drain();

    // Palette write landing on the edge that pixel A reads index 5 in S3
    pixel(205, 103);              // A: old colour
    mpal[5] = 24'h00FF00;
    pixel(206, 103);              // B: new colour
    tick();
    pal_write(5, 24'h00FF00, 1'b0);
    drain();

    // Collision flags (all zero when the option is not built)
    for (int k = 0; k < 100; k++) begin
      rom_mem[1][12'h300 + k] = 6'd3;
      rom_mem[4][12'h400 + k] = 6'd4;
    end
    spr_write(1, 1, 300, 300, 10, 10, 12'h300);
    spr_write(4, 1, 300, 300, 10, 10, 12'h400);
    pixel(303, 303);
    drain();
    check("coll_set", collision, mcoll);
    pixel(0, 0);
    drain();
    check("coll_hold", collision, mcoll);
    frame_start = 1'b1;
    tick();
    mcoll = '0;
    drain();
    check("coll_clear", collision, mcoll);
    pixel(303, 303);
    tick();
    frame_start = 1'b1;           // meets S2 of the colliding pixel
    tick();
    drain();
    check("coll_fs_same_cycle", collision, mcoll);
    frame_start = 1'b1;
    tick();
    mcoll = '0;
    drain();

    // Randomized scene
    for (int i = 0; i < 64; i++) pal_write(i, $urandom & 24'hFFFFFF);
    mbg    = $urandom & 24'hFFFFFF;
    bg_rgb = 24'(mbg);
    for (int i = 0; i < N; i++)
      spr_write(i, $urandom_range(0, 3) != 0, $urandom_range(0, 100), $urandom_range(0, 60),
                $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 4095));
    for (int k = 0; k < 400; k++)
      pixel($urandom_range(0, 150), $urandom_range(0, 110), $urandom_range(0, 3) != 0);
    drain();
    check("coll_random", collision, mcoll);

    // Reset mid-stream discards in-flight pixels
    for (int k = 0; k < 5; k++) pixel($urandom_range(0, 150), $urandom_range(0, 110));
    Reset = 1'b0;
    pix_valid = 1'b1;
    DrawX = CW'(60);
    DrawY = CW'(60);
    @(posedge Clk);
    #1;
    check("midrst_rgb_valid", rgb_valid, 0);
    check("midrst_rom_addr", rom_addr, 0);
    exp_q.delete();
    model_reset();
    @(posedge Clk);
    #1;
    pix_valid = 1'b0;
    Reset = 1'b1;

    // After reset the palette is black and the table empty
    pixel(60, 60);
    spr_write(0, 1, 10, 10, 4, 4, 0);
    pixel(11, 11);
    pixel(0, 0);
    drain();
    check("post_rst_collision", collision, mcoll);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL lost_pixels: outstanding %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
